// File: rtl/niosqsys_tx_dados_pkg.sv
// ============================================================================
// Module      : niosqsys_tx_dados_pkg
// Description : Register map and bit positions for the Nios II transmit port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package niosqsys_tx_dados_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EVENT   = 2'd3;

    localparam int EV_DRAINED   = 0;
    localparam int EV_OVERFLOW  = 1;
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/niosqsys_tx_dados_if.sv
// ============================================================================
// Module      : niosqsys_tx_dados_if
// Description : Avalon-MM slave bus plus valid/ready byte stream and irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface niosqsys_tx_dados_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        irq;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_data, out_valid, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_data, out_valid, irq
    );

endinterface

`default_nettype wire

// File: rtl/niosqsys_tx_fifo.sv
// ============================================================================
// Module      : niosqsys_tx_fifo
// Description : DEPTH x 8 synchronous FIFO; head reads 0 while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module niosqsys_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [7:0]                 wdata,
    output logic      [7:0]                 head,
    output logic      [$clog2(DEPTH):0]     count,
    output logic                            full,
    output logic                            empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Full/empty are pre-edge, so a same-cycle pop never rescues a push.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/niosqsys_tx_dados.sv
// ============================================================================
// Module      : niosqsys_tx_dados
// Description : Avalon-MM transmit port: CPU byte writes queued to a FIFO and
//               drained over valid/ready, with status, events and interrupt.
//               NIOSQSYS_TX_DADOS_IRQ_EN enables the irq mask and irq output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module niosqsys_tx_dados
    import niosqsys_tx_dados_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    niosqsys_tx_dados_if.slave      bus
);

    localparam int AW = $clog2(DEPTH);

    logic          wr, push, pop, ev_clr;
    logic [7:0]    fifo_head;
    logic [AW:0]   fifo_count;
    logic          fifo_full, fifo_empty;
    logic [31:0]   status_w;
    logic [1:0]    mask_rd;
    logic [1:0]    event_q, event_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          unused_wdata;

    assign wr     = bus.chipselect && !bus.write_n;
    assign push   = wr && (bus.address == ADDR_DATA);
    assign ev_clr = wr && (bus.address == ADDR_EVENT);
    assign pop    = bus.out_valid && bus.out_ready;
    assign unused_wdata = ^bus.writedata[31:8];

    niosqsys_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (bus.writedata[7:0]),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.out_data  = fifo_head;
    assign bus.out_valid = !fifo_empty;
    assign bus.readdata  = readdata_q;

`ifdef NIOSQSYS_TX_DADOS_IRQ_EN
    logic [1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (wr && (bus.address == ADDR_IRQMASK)) begin
            mask_d = bus.writedata[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= 2'b00;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_rd = mask_q;
    assign bus.irq = |(event_q & mask_q);
`else
    assign mask_rd = 2'b00;
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        status_w                         = '0;
        status_w[ST_EMPTY]               = fifo_empty;
        status_w[ST_FULL]                = fifo_full;
        status_w[ST_COUNT_LSB +: 5]      = 5'(fifo_count);
    end

    // Clear is applied last so it wins over a same-cycle set.
    always_comb begin
        event_d = event_q;
        if (pop && (fifo_count == (AW+1)'(1)) && !push) begin
            event_d[EV_DRAINED] = 1'b1;
        end
        if (push && fifo_full) begin
            event_d[EV_OVERFLOW] = 1'b1;
        end
        if (ev_clr) begin
            event_d = 2'b00;
        end
    end

    always_comb begin
        case (bus.address)
            ADDR_DATA:    readdata_d = {24'h0, fifo_head};
            ADDR_STATUS:  readdata_d = status_w;
            ADDR_IRQMASK: readdata_d = {30'h0, mask_rd};
            ADDR_EVENT:   readdata_d = {30'h0, event_q};
            default:      readdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_q    <= 2'b00;
            readdata_q <= 32'h0;
        end else begin
            event_q    <= event_d;
            readdata_q <= readdata_d;
        end
    end

endmodule

`default_nettype wire
